// File: rtl/retire_trace_buffer_pkg.sv
// Shared layout of the writeback pipeline register, the trace record and the
// trace capture state encodings.
package retire_trace_buffer_pkg;

    localparam int PIPE_LEN    = 102;
    localparam int PC_LSB      = 0;
    localparam int INSTR_LSB   = 32;
    localparam int RD_LSB      = 64;
    localparam int RD_DATA_LSB = 69;
    localparam int WE_BIT      = 101;

    localparam int TRACE_REC_W = 134;

    typedef enum logic [1:0] {
        TRC_CAPTURE = 2'd0,
        TRC_POST    = 2'd1,
        TRC_FROZEN  = 2'd2
    } trc_state_t;

    // Field order fixes the record bit layout: pc occupies the MSBs, we the LSB.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd_data;
        logic [31:0] cycle;
        logic [4:0]  rd;
        logic        we;
    } trace_rec_t;

    function automatic trace_rec_t pack_record(input logic [PIPE_LEN-1:0] pipe,
                                               input logic [31:0] cycle);
        trace_rec_t r;
        r.pc      = pipe[PC_LSB +: 32];
        r.instr   = pipe[INSTR_LSB +: 32];
        r.rd_data = pipe[RD_DATA_LSB +: 32];
        r.cycle   = cycle;
        r.rd      = pipe[RD_LSB +: 5];
        r.we      = pipe[WE_BIT];
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead circular FIFO with extra-MSB pointers, asynchronous reset and
// synchronous flush.
module trace_fifo #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign wr_en = push && !flush && (!full || pop);
    assign rd_en = pop && !flush && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: packs each retiring writeback record into a FIFO,
// with a PC-match trigger that freezes capture after POST_TRIG more retirements.
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [PIPE_LEN-1:0]    pipeReg,
    input  logic                   i_retire_valid,
    input  logic [31:0]            Cycle_count,
    input  logic                   i_trig_en,
    input  logic [31:0]            i_trig_pc,
    input  logic                   i_rearm,
    input  logic                   i_flush,
    output logic                   o_trace_valid,
    input  logic                   i_trace_ready,
    output logic [31:0]            o_trace_pc,
    output logic [31:0]            o_trace_instr,
    output logic [31:0]            o_trace_rd_data,
    output logic [31:0]            o_trace_cycle,
    output logic [4:0]             o_trace_rd,
    output logic                   o_trace_we,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [15:0]            o_overflow_cnt,
    output logic                   o_frozen
);

    localparam logic [7:0]  POST_LOAD = 8'(POST_TRIG);
    localparam trc_state_t  TRIG_NEXT = (POST_TRIG == 0) ? TRC_FROZEN : TRC_POST;

    trc_state_t state;
    trc_state_t state_next;
    logic [7:0]  post_cnt;
    logic [7:0]  post_next;
    logic [15:0] ovf_cnt;
    logic [15:0] ovf_next;
    logic        capturing;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    trace_rec_t  rec;
    trace_rec_t  head;

    assign rec = pack_record(pipeReg, Cycle_count);
    assign pop = !empty && i_trace_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= TRC_CAPTURE;
            post_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            state    <= state_next;
            post_cnt <= post_next;
            ovf_cnt  <= ovf_next;
        end
    end

    // Flush wins over everything and holds the state machine where it is.
    always_comb begin
        state_next = state;
        post_next  = post_cnt;
        ovf_next   = ovf_cnt;
        push       = 1'b0;
        capturing  = (state == TRC_CAPTURE) || (state == TRC_POST);
        if (i_flush) begin
            ovf_next = '0;
        end else begin
            if (i_retire_valid && capturing) begin
                if (!full || pop) begin
                    push = 1'b1;
                end else if (ovf_cnt != 16'hFFFF) begin
                    ovf_next = ovf_cnt + 16'd1;
                end
            end
            case (state)
                TRC_CAPTURE: begin
                    if (i_retire_valid && i_trig_en && (rec.pc == i_trig_pc)) begin
                        post_next  = POST_LOAD;
                        state_next = TRIG_NEXT;
                    end
                end
                TRC_POST: begin
                    // Dropped retirements still consume the post-trigger budget.
                    if (i_retire_valid) begin
                        post_next = post_cnt - 8'd1;
                        if (post_cnt == 8'd1) state_next = TRC_FROZEN;
                    end
                end
                TRC_FROZEN: begin
                    if (i_rearm) state_next = TRC_CAPTURE;
                end
                default: state_next = TRC_CAPTURE;
            endcase
        end
    end

    trace_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .flush     (i_flush),
        .push      (push),
        .push_data (rec),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (o_count)
    );

    // Head fields read as zero while empty so reset clears every output at once.
    assign o_trace_valid   = !empty;
    assign o_trace_pc      = empty ? '0 : head.pc;
    assign o_trace_instr   = empty ? '0 : head.instr;
    assign o_trace_rd_data = empty ? '0 : head.rd_data;
    assign o_trace_cycle   = empty ? '0 : head.cycle;
    assign o_trace_rd      = empty ? '0 : head.rd;
    assign o_trace_we      = empty ? 1'b0 : head.we;
    assign o_overflow_cnt  = ovf_cnt;
    assign o_frozen        = (state == TRC_FROZEN);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer with a queue-based reference model
// compared every cycle, plus literal expectations for the scripted scenarios.
module tb_retire_trace_buffer;
    import retire_trace_buffer_pkg::*;

    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                i_reset = 1'b1;
    logic [PIPE_LEN-1:0] pipeReg = '0;
    logic                i_retire_valid = 1'b0;
    logic [31:0]         cyc = 32'd0;
    logic                i_trig_en = 1'b0;
    logic [31:0]         i_trig_pc = 32'd0;
    logic                i_rearm = 1'b0;
    logic                i_flush = 1'b0;
    logic                i_trace_ready = 1'b0;
    logic                o_trace_valid;
    logic [31:0]         o_trace_pc, o_trace_instr, o_trace_rd_data, o_trace_cycle;
    logic [4:0]          o_trace_rd;
    logic                o_trace_we;
    logic [CW-1:0]       o_count;
    logic [15:0]         o_overflow_cnt;
    logic                o_frozen;

    logic [31:0] cur_pc = 32'd0;
    int n_checks = 0;
    int n_errors = 0;

    retire_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .i_clk(clk), .i_reset(i_reset), .pipeReg(pipeReg),
        .i_retire_valid(i_retire_valid), .Cycle_count(cyc),
        .i_trig_en(i_trig_en), .i_trig_pc(i_trig_pc), .i_rearm(i_rearm),
        .i_flush(i_flush), .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_pc(o_trace_pc), .o_trace_instr(o_trace_instr),
        .o_trace_rd_data(o_trace_rd_data), .o_trace_cycle(o_trace_cycle),
        .o_trace_rd(o_trace_rd), .o_trace_we(o_trace_we), .o_count(o_count),
        .o_overflow_cnt(o_overflow_cnt), .o_frozen(o_frozen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return 32'h0000_0013 + (pc << 8);
    endfunction
    function automatic logic [31:0] f_rd_data(input logic [31:0] pc);
        return pc * 3 + 32'd1;
    endfunction
    function automatic logic [4:0] f_rd(input logic [31:0] pc);
        return pc[6:2];
    endfunction
    function automatic logic f_we(input logic [31:0] pc);
        return pc[3];
    endfunction

    function automatic logic [PIPE_LEN-1:0] mk_pipe(input logic [31:0] pc);
        logic [PIPE_LEN-1:0] p;
        p = '0;
        p[PC_LSB +: 32]      = pc;
        p[INSTR_LSB +: 32]   = f_instr(pc);
        p[RD_DATA_LSB +: 32] = f_rd_data(pc);
        p[RD_LSB +: 5]       = f_rd(pc);
        p[WE_BIT]            = f_we(pc);
        return p;
    endfunction

    function automatic logic [133:0] model_rec(input logic [31:0] pc, input logic [31:0] c);
        return {pc, f_instr(pc), f_rd_data(pc), c, f_rd(pc), f_we(pc)};
    endfunction

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = capturing, 1 = post-trigger, 2 = frozen.
    logic [133:0] mq[$];
    int m_ovf = 0;
    int m_state = 0;
    int m_post = 0;

    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            mq.delete();
            m_ovf = 0;
            m_state = 0;
            m_post = 0;
        end else if (i_flush) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            if (mq.size() > 0 && i_trace_ready) void'(mq.pop_front());
            if (i_retire_valid && m_state != 2) begin
                if (mq.size() < DEPTH) mq.push_back(model_rec(cur_pc, cyc));
                else if (m_ovf < 65535) m_ovf++;
            end
            if (i_retire_valid && m_state == 0 && i_trig_en && cur_pc == i_trig_pc) begin
                m_post = POST_TRIG;
                m_state = (POST_TRIG == 0) ? 2 : 1;
            end else if (i_retire_valid && m_state == 1) begin
                m_post--;
                if (m_post == 0) m_state = 2;
            end else if (m_state == 2 && i_rearm) begin
                m_state = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!i_reset) begin
            chk("valid", 134'(o_trace_valid), 134'(mq.size() > 0));
            chk("count", 134'(o_count), 134'(mq.size()));
            chk("overflow", 134'(o_overflow_cnt), 134'(m_ovf));
            chk("frozen", 134'(o_frozen), 134'(m_state == 2));
            if (mq.size() > 0)
                chk("head", {o_trace_pc, o_trace_instr, o_trace_rd_data, o_trace_cycle,
                             o_trace_rd, o_trace_we}, mq[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc);
        cur_pc = pc;
        pipeReg = mk_pipe(pc);
        i_retire_valid = 1'b1;
        step();
        i_retire_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", 134'(o_trace_valid), 134'd0);
        chk("rst_count", 134'(o_count), 134'd0);
        chk("rst_frozen", 134'(o_frozen), 134'd0);
        i_reset = 1'b0;
        step();

        // basic capture and in-order drain
        retire(32'h100);
        retire(32'h104);
        retire(32'h108);
        chk("basic_count", 134'(o_count), 134'd3);
        chk("basic_head0", 134'(o_trace_pc), 134'h100);
        i_trace_ready = 1'b1;
        step();
        chk("basic_head1", 134'(o_trace_pc), 134'h104);
        step();
        chk("basic_head2", 134'(o_trace_pc), 134'h108);
        step();
        chk("basic_empty", 134'(o_trace_valid), 134'd0);
        i_trace_ready = 1'b0;

        // overflow with no pop
        for (int i = 0; i < 20; i++) retire(32'h1000 + 32'(4 * i));
        chk("ovf_count", 134'(o_count), 134'd16);
        chk("ovf_cnt", 134'(o_overflow_cnt), 134'd4);
        chk("ovf_head", 134'(o_trace_pc), 134'h1000);

        // push and pop while full
        i_trace_ready = 1'b1;
        for (int i = 0; i < 10; i++) retire(32'h2000 + 32'(4 * i));
        chk("full_count", 134'(o_count), 134'd16);
        chk("full_ovf", 134'(o_overflow_cnt), 134'd4);
        chk("full_head", 134'(o_trace_pc), 134'h1028);
        for (int i = 0; i < 16; i++) step();
        chk("drain_count", 134'(o_count), 134'd0);
        i_trace_ready = 1'b0;

        // trigger freeze
        i_trig_pc = 32'h200;
        i_trig_en = 1'b1;
        retire(32'h1F8);
        retire(32'h1FC);
        retire(32'h200);
        chk("trig_post", 134'(o_frozen), 134'd0);
        retire(32'h204);
        retire(32'h208);
        chk("trig_frozen", 134'(o_frozen), 134'd1);
        retire(32'h20C);
        chk("trig_count", 134'(o_count), 134'd5);
        chk("trig_ovf", 134'(o_overflow_cnt), 134'd4);

        // flush together with a retire, state unchanged
        i_flush = 1'b1;
        retire(32'h300);
        i_flush = 1'b0;
        chk("flush_count", 134'(o_count), 134'd0);
        chk("flush_ovf", 134'(o_overflow_cnt), 134'd0);
        chk("flush_frozen", 134'(o_frozen), 134'd1);

        // rearm resumes capture; trigger disabled ignores a matching pc
        i_rearm = 1'b1;
        step();
        i_rearm = 1'b0;
        chk("rearm_frozen", 134'(o_frozen), 134'd0);
        i_trig_en = 1'b0;
        retire(32'h400);
        chk("rearm_head", 134'(o_trace_pc), 134'h400);
        retire(32'h200);
        chk("notrig_frozen", 134'(o_frozen), 134'd0);
        chk("rearm_count", 134'(o_count), 134'd2);

        // freeze again, then reset mid-drain
        i_trig_en = 1'b1;
        retire(32'h200);
        retire(32'h204);
        retire(32'h208);
        chk("refreeze", 134'(o_frozen), 134'd1);
        i_trace_ready = 1'b1;
        step();
        chk("mid_valid", 134'(o_trace_valid), 134'd1);
        i_reset = 1'b1;
        #1;
        chk("arst_valid", 134'(o_trace_valid), 134'd0);
        chk("arst_count", 134'(o_count), 134'd0);
        chk("arst_frozen", 134'(o_frozen), 134'd0);
        chk("arst_fields", {o_trace_pc, o_trace_instr, o_trace_rd_data, o_trace_cycle,
                            o_trace_rd, o_trace_we}, 134'd0);
        step();
        i_reset = 1'b0;
        i_trace_ready = 1'b0;
        i_trig_en = 1'b0;
        step();
        retire(32'h500);
        chk("post_rst_count", 134'(o_count), 134'd1);
        chk("post_rst_head", 134'(o_trace_pc), 134'h500);
        chk("post_rst_frozen", 134'(o_frozen), 134'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
